// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/flush sequencing for load-use, taken branches and data-memory waits
module hazard_control_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_uses_rs2,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;
    localparam logic [3:0]  FC = 4'(FLUSH_CYCLES);
    localparam logic [15:0] MT = 16'(MEM_TIMEOUT);
    state_t      state, state_nx;
    logic        ret_flush, ret_flush_nx;
    logic [3:0]  flush_cnt, flush_cnt_nx;
    logic [15:0] wait_cnt, wait_cnt_nx;
    logic        accept_branch;
    logic        mem_busy, load_use, eff_flush;
    assign mem_busy  = dmem_req & ~dmem_ready;
    assign load_use  = id_ex_mem_read & (id_ex_rd != 5'd0) &
                       ((id_ex_rd == if_id_rs1) | (if_id_uses_rs2 & (id_ex_rd == if_id_rs2)));
    // a released memory wait resumes whichever sequence it interrupted
    assign eff_flush = (state == FLUSH) | ((state == MEM_WAIT) & ret_flush);
    // priority chain: reset > mem_busy > branch > flush sequence > load-use > normal
    always_comb begin
        state_nx      = state;
        ret_flush_nx  = ret_flush;
        flush_cnt_nx  = flush_cnt;
        wait_cnt_nx   = '0;
        accept_branch = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            state_nx     = MEM_WAIT;
            ret_flush_nx = (state == MEM_WAIT) ? ret_flush : (state == FLUSH);
            wait_cnt_nx  = (wait_cnt >= MT) ? wait_cnt : wait_cnt + 16'd1;
        end else if (branch_taken) begin
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            accept_branch = 1'b1;
            state_nx      = (FC != 4'd0) ? FLUSH : RUN;
            flush_cnt_nx  = FC;
        end else if (eff_flush) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            state_nx     = (flush_cnt <= 4'd1) ? RUN : FLUSH;
            flush_cnt_nx = (flush_cnt == 4'd0) ? 4'd0 : flush_cnt - 4'd1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            state_nx    = RUN;
        end else begin
            state_nx = RUN;
        end
    end
    // state, wait tracking, sticky timeout and saturating performance counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            ret_flush    <= 1'b0;
            flush_cnt    <= '0;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state     <= state_nx;
            ret_flush <= ret_flush_nx;
            flush_cnt <= flush_cnt_nx;
            wait_cnt  <= wait_cnt_nx;
            if (mem_busy && wait_cnt_nx >= MT)
                mem_timeout <= 1'b1;
            if (!pc_write && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (accept_branch && flush_events != '1)
                flush_events <= flush_events + 1'b1;
        end
    end
endmodule
